axis_word_packer: RTL

Synthesizable stage directly downstream of the binary-file word reader. It accepts one IN_WIDTH-bit word per handshake and packs RATIO consecutive words into one wide AXI-Stream beat. It marks frame boundaries with tlast every FRAME_BEATS beats or at end of stream. Its output feeds the DUT or the binary-file word writer through a standard AXIS slave.

---
 rtl/axis_word_packer.sv | 94 +++++++++
 1 files changed

// File: rtl/axis_word_packer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | axis_word_packer: packs RATIO narrow words into one wide AXIS beat,      |
// | with tlast every FRAME_BEATS beats or at end of stream.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_word_packer #(
  parameter int IN_WIDTH    = 32,
  parameter int RATIO       = 4,
  parameter int FRAME_BEATS = 16
) (
  input  logic                           aclk,
  input  logic                           arst,
  input  logic [IN_WIDTH-1:0]            s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [IN_WIDTH*RATIO-1:0]      m_axis_tdata,
  output logic [IN_WIDTH*RATIO/8-1:0]    m_axis_tkeep,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready
);

  localparam int OUT_WIDTH  = IN_WIDTH * RATIO;
  localparam int KEEP_WIDTH = OUT_WIDTH / 8;
  localparam int LANE_BYTES = IN_WIDTH / 8;
  localparam int LANE_CW    = $clog2(RATIO);
  localparam int BEAT_CW    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(RATIO - 1);
  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(FRAME_BEATS - 1);

  logic [OUT_WIDTH-1:0]  acc_data;
  logic [KEEP_WIDTH-1:0] acc_keep;
  logic [OUT_WIDTH-1:0]  merged_data;
  logic [KEEP_WIDTH-1:0] merged_keep;
  logic [LANE_CW-1:0]    lane_cnt;
  logic [BEAT_CW-1:0]    beat_cnt;
  logic                  accept;
  logic                  complete;
  logic                  beat_last;

  // Ready only depends on the output slot, so a completing word always fits.
  assign s_axis_tready = !arst && (!m_axis_tvalid || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && ((lane_cnt == LAST_LANE) || s_axis_tlast);
  assign beat_last     = s_axis_tlast || (beat_cnt == LAST_BEAT);

  always_comb begin
    merged_data = acc_data;
    merged_keep = acc_keep;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_cnt == LANE_CW'(k)) begin
        merged_data[k*IN_WIDTH +: IN_WIDTH]     = s_axis_tdata;
        merged_keep[k*LANE_BYTES +: LANE_BYTES] = '1;
      end
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      acc_data      <= '0;
      acc_keep      <= '0;
      lane_cnt      <= '0;
      beat_cnt      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (complete) begin
      // Load replaces any beat draining this cycle, so there is no bubble.
      m_axis_tdata  <= merged_data;
      m_axis_tkeep  <= merged_keep;
      m_axis_tlast  <= beat_last;
      m_axis_tvalid <= 1'b1;
      acc_data      <= '0;
      acc_keep      <= '0;
      lane_cnt      <= '0;
      beat_cnt      <= beat_last ? '0 : beat_cnt + 1'b1;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        acc_data <= merged_data;
        acc_keep <= merged_keep;
        lane_cnt <= lane_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
